// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, ID-resolved
// branch flushes, multi-cycle MUL/DIV holds and a saturating stall counter.
module pipeline_hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_Rs1_i,
  input  logic [4:0]       ID_Rs2_i,
  input  logic [4:0]       EX_Rd_i,
  input  logic             EX_MemRead_i,
  input  logic             ID_MulDiv_i,
  input  logic             Branch_taken_i,
  output logic             PCWrite_o,
  output logic             IFID_Write_o,
  output logic             IFID_Flush_o,
  output logic             IDEX_Bubble_o,
  output logic             IDEX_Hold_o,
  output logic             Busy_o,
  output logic [CNT_W-1:0] StallCnt_o
);

  localparam logic [0:0] S_RUN     = 1'b0;
  localparam logic [0:0] S_MD_WAIT = 1'b1;
  localparam logic [3:0] MD_INIT   = 4'(MD_LATENCY - 1);

  logic [0:0]       r_state, w_state_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_load_use;

  assign w_load_use = EX_MemRead_i && (EX_Rd_i != 5'd0) &&
                      ((EX_Rd_i == ID_Rs1_i) || (EX_Rd_i == ID_Rs2_i));

  always_comb begin
    PCWrite_o     = 1'b1;
    IFID_Write_o  = 1'b1;
    IFID_Flush_o  = 1'b0;
    IDEX_Bubble_o = 1'b0;
    IDEX_Hold_o   = 1'b0;
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    if (rst_i) begin
      PCWrite_o     = 1'b0;
      IFID_Write_o  = 1'b0;
      IFID_Flush_o  = 1'b1;
      IDEX_Bubble_o = 1'b1;
      w_state_nxt   = S_RUN;
      w_cnt_nxt     = 4'd0;
    end else if (r_state == S_MD_WAIT) begin
      // Hazards and branches are frozen while the MUL/DIV owns EX.
      PCWrite_o    = 1'b0;
      IFID_Write_o = 1'b0;
      IDEX_Hold_o  = 1'b1;
      w_cnt_nxt    = r_cnt - 4'd1;
      if (r_cnt == 4'd1) w_state_nxt = S_RUN;
    end else if (w_load_use) begin
      PCWrite_o     = 1'b0;
      IFID_Write_o  = 1'b0;
      IDEX_Bubble_o = 1'b1;
    end else if (Branch_taken_i) begin
      IFID_Flush_o = 1'b1;
    end else if (ID_MulDiv_i) begin
      w_state_nxt = S_MD_WAIT;
      w_cnt_nxt   = MD_INIT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_RUN;
      r_cnt       <= 4'd0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (!PCWrite_o && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign Busy_o     = (r_state == S_MD_WAIT);
  assign StallCnt_o = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed + randomized bench for pipeline_hazard_ctrl against a cycle-level
// behavioural model (remaining-hold count, saturating stall total).
module tb_pipeline_hazard_ctrl;
  localparam int LAT   = 4;
  localparam int CW    = 4;
  localparam int SMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    rs1 = '0, rs2 = '0, rd = '0;
  logic          memrd = 1'b0, muldiv = 1'b0, br = 1'b0;
  logic          pcw, ifw, flush, bub, hold, busy;
  logic [CW-1:0] scnt;

  int checks = 0;
  int errors = 0;

  // model state
  int hold_left = 0;
  int stalls    = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MD_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .ID_Rs1_i(rs1), .ID_Rs2_i(rs2), .EX_Rd_i(rd),
    .EX_MemRead_i(memrd), .ID_MulDiv_i(muldiv), .Branch_taken_i(br),
    .PCWrite_o(pcw), .IFID_Write_o(ifw), .IFID_Flush_o(flush),
    .IDEX_Bubble_o(bub), .IDEX_Hold_o(hold), .Busy_o(busy), .StallCnt_o(scnt)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs away from the edge, check outputs, advance model.
  task automatic step(input logic r, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] d, input logic mr, input logic md, input logic bt);
    int e_pc, e_ifw, e_fl, e_bub, e_hold, e_busy;
    bit lu;
    @(negedge clk);
    rst = r; rs1 = a; rs2 = b; rd = d; memrd = mr; muldiv = md; br = bt;
    #1;
    lu = mr && (d != 0) && (d == a || d == b);
    e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; e_hold = 0;
    e_busy = (hold_left > 0);
    if (r) begin
      e_pc = 0; e_ifw = 0; e_fl = 1; e_bub = 1;
    end else if (hold_left > 0) begin
      e_pc = 0; e_ifw = 0; e_hold = 1;
    end else if (lu) begin
      e_pc = 0; e_ifw = 0; e_bub = 1;
    end else if (bt) begin
      e_fl = 1;
    end
    chk("PCWrite", int'(pcw), e_pc);
    chk("IFID_Write", int'(ifw), e_ifw);
    chk("IFID_Flush", int'(flush), e_fl);
    chk("IDEX_Bubble", int'(bub), e_bub);
    chk("IDEX_Hold", int'(hold), e_hold);
    chk("Busy", int'(busy), e_busy);
    chk("StallCnt", int'(scnt), stalls);
    // model update for the coming edge
    if (r) begin
      hold_left = 0; stalls = 0;
    end else begin
      if (e_pc == 0 && stalls < SMAX) stalls++;
      if (hold_left > 0) hold_left--;
      else if (!lu && !bt && md) hold_left = LAT - 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 5'd1, 5'd2, 5'd3, 0, 0, 0);
  endtask

  initial begin
    // reset
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(1);
    // load-use on rs2, then the same with rd=0
    step(0, 5'd1, 5'd5, 5'd5, 1, 0, 0);
    idle(1);
    step(0, 5'd0, 5'd0, 5'd0, 1, 0, 0);
    // load-use on rs1
    step(0, 5'd7, 5'd2, 5'd7, 1, 0, 0);
    // taken branch alone, then with load-use, then with illegal muldiv
    step(0, 5'd1, 5'd2, 5'd3, 0, 0, 1);
    step(0, 5'd1, 5'd5, 5'd5, 1, 0, 1);
    step(0, 5'd1, 5'd2, 5'd3, 0, 1, 1);
    idle(1);
    // MUL/DIV with branch pulse at t+2 and back-to-back MUL/DIV at t+4
    step(0, 5'd1, 5'd2, 5'd3, 0, 1, 0);
    step(0, 5'd1, 5'd2, 5'd3, 0, 0, 0);
    step(0, 5'd1, 5'd2, 5'd3, 0, 0, 1);
    step(0, 5'd1, 5'd5, 5'd5, 1, 0, 0);
    step(0, 5'd1, 5'd2, 5'd3, 0, 1, 0);
    idle(4);
    // reset in the middle of a hold
    step(0, 5'd1, 5'd2, 5'd3, 0, 1, 0);
    step(0, 5'd1, 5'd2, 5'd3, 0, 0, 0);
    step(1, 5'd1, 5'd2, 5'd3, 0, 0, 0);
    step(1, 5'd1, 5'd2, 5'd3, 0, 0, 0);
    idle(2);
    // saturation: 20 cycles of load-use
    for (int i = 0; i < 20; i++) step(0, 5'd9, 5'd4, 5'd9, 1, 0, 0);
    idle(2);
    step(1, 0, 0, 0, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 2),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 20));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. It drives the write-enable, flush and bubble controls of PC, IF/ID and ID/EX. It detects load-use hazards and taken branches resolved in ID. It also holds the pipeline while a multi-cycle MUL/DIV occupies EX, and counts stall cycles for performance monitoring.

Parameters:
MD_LATENCY, 4, total cycles a MUL/DIV occupies EX (legal range 2..15)
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous, active-high reset
ID_Rs1_i  in  5  rs1 field (19-15) of instruction in ID
ID_Rs2_i  in  5  rs2 field (24-20) of instruction in ID
EX_Rd_i  in  5  rd field (11-7) held in ID/EX
EX_MemRead_i  in  1  MemRead held in ID/EX
ID_MulDiv_i  in  1  instruction in ID is MUL/DIV class
Branch_taken_i  in  1  branch in ID resolved taken
PCWrite_o  out  1  PC load enable
IFID_Write_o  out  1  IF/ID load enable
IFID_Flush_o  out  1  IF/ID clears to NOP
IDEX_Bubble_o  out  1  zero all control bits loaded into ID/EX
IDEX_Hold_o  out  1  ID/EX keeps current contents
Busy_o  out  1  MUL/DIV hold in progress
StallCnt_o  out  CNT_W  saturating count of stall cycles

Behaviour:
- State register: RUN, MD_WAIT. Down-counter cnt is 4 bits. Outputs are combinational from state, cnt and inputs.
- load_use = EX_MemRead_i & (EX_Rd_i != 0) & (EX_Rd_i == ID_Rs1_i | EX_Rd_i == ID_Rs2_i).
- Default outputs in RUN: PCWrite=1, IFID_Write=1, Flush=0, Bubble=0, Hold=0.
- RUN, priority order:
  1. load_use: PCWrite=0, IFID_Write=0, Bubble=1. Branch_taken_i and ID_MulDiv_i are ignored this cycle and re-evaluated next cycle. Stay in RUN.
  2. else Branch_taken_i: IFID_Flush=1, PCWrite=1. If ID_MulDiv_i is also set (illegal), it is ignored. Stay in RUN.
  3. else ID_MulDiv_i: default outputs, so the instruction advances into ID/EX. Next state MD_WAIT, cnt <= MD_LATENCY-1.
- MD_WAIT: PCWrite=0, IFID_Write=0, Hold=1, Bubble=0, Flush=0. load_use and Branch_taken_i are ignored. cnt decrements each cycle; when cnt==1, next state is RUN.
- Timing: MD_WAIT lasts exactly MD_LATENCY-1 cycles, so the MUL/DIV spends MD_LATENCY cycles in EX.
- Back in RUN, hazards are evaluated normally that same cycle. A back-to-back MUL/DIV re-enters MD_WAIT with no gap.
- Busy_o = (state == MD_WAIT).
- StallCnt_o increments at the clock edge of every cycle in which PCWrite_o==0 and rst_i==0. It saturates at 2^CNT_W-1 and does not wrap.
- Reset, while rst_i=1:
  - Outputs forced: PCWrite=0, IFID_Write=0, IFID_Flush=1, IDEX_Bubble=1, IDEX_Hold=0.
  - At the edge: state <= RUN, cnt <= 0, StallCnt_o <= 0.
  - After release, Busy_o=0 and StallCnt_o=0.
  - Reset asserted mid-MD_WAIT aborts the hold; the first cycle after release is RUN.
- EX_Rd_i==0 never causes a stall, even with EX_MemRead_i=1.

Test Plan:
- Load-use: EX_MemRead=1, EX_Rd=5, ID_Rs2=5 for 1 cycle -> PCWrite=0, IFID_Write=0, Bubble=1 for exactly 1 cycle; StallCnt 0->1. Same stimulus with EX_Rd=0 -> no stall.
- Taken branch: Branch_taken=1, no hazard -> IFID_Flush=1, PCWrite=1 for 1 cycle, StallCnt unchanged. Branch_taken=1 with load_use -> stall only, Flush=0.
- MUL/DIV, MD_LATENCY=4: ID_MulDiv=1 in cycle t -> Hold=1, Busy=1, PCWrite=0 in cycles t+1..t+3; RUN at t+4; StallCnt +3.
- Back-to-back MUL/DIV with ID_MulDiv=1 at t+4 -> MD_WAIT again at t+5..t+7. Branch_taken pulsed at t+2 -> no Flush.
- Reset at t+2 of MD_WAIT -> during reset Flush=1, Bubble=1, Hold=0. After release: RUN, Busy=0, StallCnt=0.
- Saturation with CNT_W=4: hold load_use for 20 cycles -> StallCnt reaches 15 and stays at 15.
